// File: rtl/audio_pkg.sv
// Shared audio-path types and constants for the convolution output chain.
package audio_pkg;

  typedef logic signed [15:0] sample_t;
  typedef logic signed [47:0] conv_t;

  typedef enum logic [1:0] {
    UNITY   = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2
  } limiter_state_t;

  localparam sample_t SAMPLE_MAX = 16'sh7FFF;
  localparam sample_t SAMPLE_MIN = 16'sh8000;

  // Magnitude of a 16-bit sample; the most negative value maps to 32768 without overflow.
  function automatic logic [16:0] sample_mag(input sample_t s);
    logic signed [16:0] wide;
    wide = {s[15], s};
    if (s == SAMPLE_MIN) begin
      sample_mag = 17'd32768;
    end else if (s[15]) begin
      sample_mag = 17'(-wide);
    end else begin
      sample_mag = 17'(wide);
    end
  endfunction

endpackage

// File: rtl/conv_output_limiter_shift_saturate.sv
// Arithmetic right shift and signed saturation, exposed as two independent paths
// so a pipeline register can sit between them.
module shift_saturate #(
  parameter int IN_WIDTH    = 48,
  parameter int OUT_WIDTH   = 16,
  parameter int SHIFT_WIDTH = 6
) (
  input  logic signed [IN_WIDTH-1:0]    value,
  input  logic        [SHIFT_WIDTH-1:0] shift,
  output logic signed [IN_WIDTH-1:0]    shifted,
  input  logic signed [IN_WIDTH-1:0]    wide,
  output logic signed [OUT_WIDTH-1:0]   narrow,
  output logic                          clip
);

  localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic [IN_WIDTH-OUT_WIDTH:0] upper_s;

  // Sign-preserving shift of the raw input.
  always_comb begin
    shifted = value >>> shift;
  end

  // The value fits when every bit above the output sign bit matches it.
  always_comb begin
    upper_s = wide[IN_WIDTH-1:OUT_WIDTH-1];
    if ((&upper_s) || (~|upper_s)) begin
      narrow = wide[OUT_WIDTH-1:0];
      clip   = 1'b0;
    end else if (wide[IN_WIDTH-1]) begin
      narrow = OUT_MIN;
      clip   = 1'b1;
    end else begin
      narrow = OUT_MAX;
      clip   = 1'b1;
    end
  end

endmodule

// File: rtl/conv_output_limiter.sv
// Shift/saturate stage between convolve_audio and pdm with automatic gain reduction.
// Auto gain is compiled in only when CONV_LIMITER_AUTO_GAIN_EN is defined.
module conv_output_limiter
  import audio_pkg::*;
#(
  parameter int IN_WIDTH        = 48,
  parameter int OUT_WIDTH       = 16,
  parameter int MAX_EXTRA_SHIFT = 15,
  parameter int RELEASE_SAMPLES = 2400,
  parameter int QUIET_LEVEL     = 8192
) (
  input  logic                        audio_clk,
  input  logic                        rst_in,
  input  logic                        sample_valid_in,
  input  logic signed [IN_WIDTH-1:0]  sample_in,
  input  logic        [5:0]           base_shift_in,
  output logic                        sample_valid_out,
  output logic signed [OUT_WIDTH-1:0] sample_out,
  output logic                        clip_out,
  output logic        [3:0]           gain_reduction_out
);

  localparam int SHIFT_WIDTH = $clog2(IN_WIDTH);

  logic        [3:0]             extra_s;
  logic        [6:0]             total_s;
  logic        [SHIFT_WIDTH-1:0] shift_s;
  logic signed [IN_WIDTH-1:0]    shifted_s;
  logic signed [OUT_WIDTH-1:0]   sat_s;
  logic                          clip_s;

  logic                          stage1_valid_r;
  logic signed [IN_WIDTH-1:0]    stage1_value_r;
  logic                          valid_out_r;
  logic signed [OUT_WIDTH-1:0]   sample_out_r;
  logic                          clip_r;

  // Combined shift, clamped so the shifter never exceeds the input width.
  always_comb begin
    total_s = {1'b0, base_shift_in} + {3'b000, extra_s};
    if (total_s > 7'(IN_WIDTH - 1)) begin
      shift_s = SHIFT_WIDTH'(IN_WIDTH - 1);
    end else begin
      shift_s = total_s[SHIFT_WIDTH-1:0];
    end
  end

  shift_saturate #(
    .IN_WIDTH   (IN_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH),
    .SHIFT_WIDTH(SHIFT_WIDTH)
  ) u_shift_saturate (
    .value  (sample_in),
    .shift  (shift_s),
    .shifted(shifted_s),
    .wide   (stage1_value_r),
    .narrow (sat_s),
    .clip   (clip_s)
  );

  // Two-stage data pipeline: shift into stage 1, saturate into the output registers.
  always_ff @(posedge audio_clk) begin
    if (rst_in) begin
      stage1_valid_r <= 1'b0;
      stage1_value_r <= '0;
      valid_out_r    <= 1'b0;
      sample_out_r   <= '0;
      clip_r         <= 1'b0;
    end else begin
      stage1_valid_r <= sample_valid_in;
      if (sample_valid_in) begin
        stage1_value_r <= shifted_s;
      end
      valid_out_r <= stage1_valid_r;
      clip_r      <= stage1_valid_r & clip_s;
      if (stage1_valid_r) begin
        sample_out_r <= sat_s;
      end
    end
  end

`ifdef CONV_LIMITER_AUTO_GAIN_EN
  localparam int HOLD_WIDTH = $clog2(RELEASE_SAMPLES + 1);

  limiter_state_t          state_r;
  logic [3:0]              extra_r;
  logic [HOLD_WIDTH-1:0]   hold_r;
  logic [OUT_WIDTH:0]      mag_s;
  logic                    quiet_s;
  logic [3:0]              clip_extra_s;

  // Output magnitude and the next extra shift after a clip (capped at the ceiling).
  always_comb begin
    mag_s = (OUT_WIDTH+1)'(sample_mag(sample_t'(sample_out_r)));
    quiet_s = (mag_s < (OUT_WIDTH+1)'(QUIET_LEVEL));
    if (extra_r >= 4'(MAX_EXTRA_SHIFT)) begin
      clip_extra_s = 4'(MAX_EXTRA_SHIFT);
    end else begin
      clip_extra_s = extra_r + 4'd1;
    end
  end

  // Gain FSM, stepped once per output sample.
  always_ff @(posedge audio_clk) begin
    if (rst_in) begin
      state_r <= UNITY;
      extra_r <= 4'd0;
      hold_r  <= '0;
    end else if (valid_out_r) begin
      case (state_r)
        UNITY: begin
          if (clip_r) begin
            extra_r <= clip_extra_s;
            hold_r  <= HOLD_WIDTH'(RELEASE_SAMPLES);
            state_r <= HOLD;
          end
        end
        HOLD: begin
          if (clip_r) begin
            extra_r <= clip_extra_s;
            hold_r  <= HOLD_WIDTH'(RELEASE_SAMPLES);
          end else begin
            hold_r <= hold_r - HOLD_WIDTH'(1);
            if (hold_r == HOLD_WIDTH'(1)) begin
              state_r <= RELEASE;
            end
          end
        end
        RELEASE: begin
          if (clip_r) begin
            extra_r <= clip_extra_s;
            hold_r  <= HOLD_WIDTH'(RELEASE_SAMPLES);
            state_r <= HOLD;
          end else if (quiet_s) begin
            extra_r <= extra_r - 4'd1;
            if (extra_r == 4'd1) begin
              hold_r  <= '0;
              state_r <= UNITY;
            end else begin
              hold_r  <= HOLD_WIDTH'(RELEASE_SAMPLES);
              state_r <= HOLD;
            end
          end
        end
        default: begin
          state_r <= UNITY;
          extra_r <= 4'd0;
          hold_r  <= '0;
        end
      endcase
    end
  end

  assign extra_s            = extra_r;
  assign gain_reduction_out = extra_r;
`else
  assign extra_s            = 4'd0;
  assign gain_reduction_out = 4'd0;
`endif

  assign sample_valid_out = valid_out_r;
  assign sample_out       = sample_out_r;
  assign clip_out         = clip_r;

endmodule
